// File: rtl/sum_stream_decoder.sv
// Recovers the hidden counter from out = a + b + cnt, locks onto its fixed-step sequence
// and flags/counts samples that break the sequence while locked.
module sum_stream_decoder #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STEP          = 2,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned UNLOCK_ERRORS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count
);

  localparam int unsigned HitW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW = $clog2(UNLOCK_ERRORS + 1);
  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [HitW-1:0]  hits_q, hits_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] r;
  logic [HitW-1:0]  hits_inc;
  logic [MissW-1:0] miss_inc;
  logic             match, lock_hit, unlock_hit;

  assign r          = in_sum - in_a - in_b;
  assign match      = (r == exp_q);
  assign hits_inc   = hits_q + HitW'(1);
  assign miss_inc   = miss_q + MissW'(1);
  assign lock_hit   = (hits_inc == HitW'(LOCK_COUNT));
  assign unlock_hit = (miss_inc == MissW'(UNLOCK_ERRORS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      exp_q       <= '0;
      cnt_q       <= '0;
      hits_q      <= '0;
      miss_q      <= '0;
      cnt_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
      cnt_valid_q <= cnt_valid_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      unique case (state_q)
        StSearch: state_d = StVerify;
        StVerify: if (match && lock_hit) state_d = StLocked;
        StLocked: if (!match && unlock_hit) state_d = StSearch;
        default:  state_d = StSearch;
      endcase
    end
  end

  always_comb begin
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    hits_d      = hits_q;
    miss_d      = miss_q;
    cnt_valid_d = 1'b0;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (in_valid) begin
      cnt_d       = r;
      cnt_valid_d = 1'b1;
      unique case (state_q)
        StVerify: begin
          exp_d = r + StepW;
          if (match) begin
            hits_d = hits_inc;
            if (lock_hit) miss_d = '0;
          end else begin
            hits_d = HitW'(1);
          end
        end
        StLocked: begin
          // Free-run on the expected value; a bad sample never resyncs it.
          exp_d = exp_q + StepW;
          if (match) begin
            miss_d = '0;
          end else begin
            miss_d      = miss_inc;
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
        default: begin
          exp_d  = r + StepW;
          hits_d = HitW'(1);
        end
      endcase
    end
    if (err_clr) err_count_d = '0;
  end

  always_comb begin
    locked = (state_q == StLocked);
  end

  assign cnt_out   = cnt_q;
  assign cnt_valid = cnt_valid_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sum_stream_decoder.sv
// Scoreboard bench: two decoders (UNLOCK_ERRORS 2 and 255) share one stimulus stream and are
// compared cycle by cycle against an arithmetic reference model.
module tb_sum_stream_decoder;

  localparam int STEP = 2;
  localparam int LC   = 3;

  typedef struct {
    int cnt_out;
    int cnt_valid;
    int locked;
    int err_pulse;
    int err_count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] in_sum = '0, in_a = '0, in_b = '0;

  logic [7:0] d0_cnt, d1_cnt, d0_errc, d1_errc;
  logic       d0_cv, d1_cv, d0_lk, d1_lk, d0_ep, d1_ep;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  int m_mode[2], m_e[2], m_hits[2], m_miss[2], m_cnt[2], m_errc[2];

  always #5 clk = ~clk;

  sum_stream_decoder #(.WIDTH(8), .STEP(2), .LOCK_COUNT(3), .UNLOCK_ERRORS(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_a(in_a), .in_b(in_b),
    .err_clr(err_clr), .cnt_out(d0_cnt), .cnt_valid(d0_cv), .locked(d0_lk),
    .err_pulse(d0_ep), .err_count(d0_errc)
  );

  sum_stream_decoder #(.WIDTH(8), .STEP(2), .LOCK_COUNT(3), .UNLOCK_ERRORS(255)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_a(in_a), .in_b(in_b),
    .err_clr(err_clr), .cnt_out(d1_cnt), .cnt_valid(d1_cv), .locked(d1_lk),
    .err_pulse(d1_ep), .err_count(d1_errc)
  );

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Mode 0 = searching, 1 = verifying, 2 = locked.
  task automatic model_step(input int k, input int unlock_n, output exp_t o);
    int r;
    o.cnt_valid = 0;
    o.err_pulse = 0;
    if (rst) begin
      m_mode[k] = 0; m_e[k] = 0; m_hits[k] = 0; m_miss[k] = 0; m_cnt[k] = 0; m_errc[k] = 0;
    end else begin
      if (in_valid) begin
        r = (int'(in_sum) - int'(in_a) - int'(in_b)) & 255;
        m_cnt[k] = r;
        o.cnt_valid = 1;
        if (m_mode[k] == 0) begin
          m_e[k] = (r + STEP) & 255; m_hits[k] = 1; m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
          if (r == m_e[k]) begin
            m_hits[k]++;
            if (m_hits[k] == LC) begin m_mode[k] = 2; m_miss[k] = 0; end
          end else begin
            m_hits[k] = 1;
          end
          m_e[k] = (r + STEP) & 255;
        end else begin
          if (r == m_e[k]) m_miss[k] = 0;
          else begin
            o.err_pulse = 1;
            if (m_errc[k] < 255) m_errc[k]++;
            m_miss[k]++;
            if (m_miss[k] == unlock_n) m_mode[k] = 0;
          end
          m_e[k] = (m_e[k] + STEP) & 255;
        end
      end
      if (err_clr) m_errc[k] = 0;
    end
    o.cnt_out   = m_cnt[k];
    o.locked    = (m_mode[k] == 2) ? 1 : 0;
    o.err_count = m_errc[k];
  endtask

  task automatic apply(input logic r_rst, input logic v, input logic [7:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
    exp_t e0, e1;
    @(negedge clk);
    rst = r_rst; in_valid = v; in_sum = s; in_a = a; in_b = b; err_clr = clr;
    model_step(0, 2, e0);
    model_step(1, 255, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic sendr(input int r, input logic clr);
    logic [7:0] a, b, s;
    a = 8'($urandom);
    b = 8'($urandom);
    s = 8'(r) + a + b;
    apply(1'b0, 1'b1, s, a, b, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("d0.cnt_out", int'(d0_cnt), e.cnt_out);
        cmp("d0.cnt_valid", int'(d0_cv), e.cnt_valid);
        cmp("d0.locked", int'(d0_lk), e.locked);
        cmp("d0.err_pulse", int'(d0_ep), e.err_pulse);
        cmp("d0.err_count", int'(d0_errc), e.err_count);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("d1.cnt_out", int'(d1_cnt), e.cnt_out);
        cmp("d1.cnt_valid", int'(d1_cv), e.cnt_valid);
        cmp("d1.locked", int'(d1_lk), e.locked);
        cmp("d1.err_pulse", int'(d1_ep), e.err_pulse);
        cmp("d1.err_count", int'(d1_errc), e.err_count);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int cnt, p;
    do_reset();
    do_reset();

    // Acquire from zero operands.
    apply(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    apply(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0);
    apply(1'b0, 1'b1, 8'h04, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Operand removal across the counter wrap.
    do_reset();
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 8'(8'hFC + 8'(2 * i) + 8'h10 + 8'hF0),
                                      8'h10, 8'hF0, 1'b0);
    idle(1);

    // Single glitch while locked, then unlock and relock.
    do_reset();
    sendr(0, 0); sendr(2, 0); sendr(4, 0);
    sendr(7, 0); sendr(8, 0); sendr(10, 0);
    sendr(3, 0); sendr(3, 0);
    sendr(8'h20, 0); sendr(8'h22, 0); sendr(8'h24, 0);
    idle(1);

    // Gaps and acquisition restart.
    do_reset();
    sendr(0, 0); sendr(2, 0); idle(3);
    sendr(5, 0); sendr(7, 0); sendr(9, 0);
    idle(1);

    // Saturation: alternate bad/good samples so both instances stay locked.
    do_reset();
    sendr(0, 0); sendr(2, 0); sendr(4, 0);
    for (int i = 0; i < 300; i++) begin
      sendr((m_e[1] + 1) & 255, 0);
      sendr(m_e[1], 0);
    end
    idle(2);
    sendr((m_e[1] + 1) & 255, 1);
    sendr(m_e[1], 0);
    // Reset while locked.
    do_reset();
    idle(2);

    // Randomized mostly-in-sequence traffic.
    cnt = int'($urandom_range(0, 255));
    for (int i = 0; i < 1500; i++) begin
      p = int'($urandom_range(0, 199));
      if (p < 1) do_reset();
      else if (p < 16) idle(1);
      else if (p < 28) begin
        sendr((cnt + int'($urandom_range(1, 255))) & 255, ($urandom_range(0, 31) == 0));
        cnt = (cnt + STEP) & 255;
      end else begin
        sendr(cnt, ($urandom_range(0, 31) == 0));
        cnt = (cnt + STEP) & 255;
      end
    end

    idle(2);
    @(negedge clk);
    cmp("q0_drained", q0.size(), 0);
    cmp("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_stream_decoder.md
Name: sum_stream_decoder

Overview:
- Receive end of the accumulating output stream `out = a + b + cnt`, where `cnt` is a free-running counter advancing by a fixed step per sample.
- The block takes the observed sum plus the operands that produced it, and recovers the hidden counter value.
- It acquires lock on the counter sequence, then flags and counts any sample that breaks the sequence.
- It sits beside the output-stream generator, in the same tile, as an on-chip self-checker; the caller presents sum/operand tuples already time-aligned.

Parameters:
- WIDTH, 8, datapath width of sum, operands and counter.
- STEP, 2, counter increment per valid sample.
- LOCK_COUNT, 3, consecutive in-sequence samples needed to declare lock (≥2).
- UNLOCK_ERRORS, 2, consecutive out-of-sequence samples while locked that drop lock (≥1).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, tuple on in_sum/in_a/in_b is valid this cycle.
- in_sum, input, WIDTH, observed stream value.
- in_a, input, WIDTH, first operand aligned to in_sum.
- in_b, input, WIDTH, second operand aligned to in_sum.
- err_clr, input, 1, clears err_count.
- cnt_out, output, WIDTH, last recovered counter value.
- cnt_valid, output, 1, one-cycle pulse: cnt_out updated.
- locked, output, 1, decoder is in LOCKED state.
- err_pulse, output, 1, one-cycle pulse: locked-state mismatch detected.
- err_count, output, 8, saturating count of locked-state mismatches.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset (rst=1 at a rising edge) forces all outputs to 0: cnt_out, cnt_valid, locked, err_pulse, err_count. It also clears internal hits/misses/expected and sets state SEARCH. rst overrides all other inputs, including mid-acquisition or mid-lock.
- Recovered value: r = in_sum − in_a − in_b, modulo 2^WIDTH (wrap, no saturation). Expected next value: e. All additions to e are modulo 2^WIDTH, so e = 0xFF + 2 wraps to 0x01.
- All outputs are registered, with 1-cycle latency from the sampled tuple.
- On each valid sample: cnt_out ← r, cnt_valid = 1. cnt_valid = 0 whenever in_valid = 0.
- in_valid=0: state, e, hits, misses and outputs hold, except cnt_valid and err_pulse, which are 0.
- SEARCH, on valid: e ← r+STEP, hits ← 1, go to VERIFY.
- VERIFY, valid with r == e:
  - hits ← hits+1, e ← r+STEP.
  - If hits+1 == LOCK_COUNT: go to LOCKED, misses ← 0, locked = 1 from the next cycle.
- VERIFY, valid with r ≠ e: restart acquisition from this sample (e ← r+STEP, hits ← 1), stay in VERIFY. No err_pulse; err_count unchanged.
- LOCKED, valid with r == e: e ← e+STEP, misses ← 0.
- LOCKED, valid with r ≠ e:
  - err_pulse = 1 for one cycle; err_count ← min(err_count+1, 255).
  - misses ← misses+1; e ← e+STEP (free-run, no resync on r).
  - If misses+1 == UNLOCK_ERRORS: go to SEARCH, locked = 0 from the next cycle.
- err_clr: err_count ← 0. If err_clr coincides with an increment, clear wins (result 0). err_pulse is still asserted.
- err_count holds at 255 until err_clr or rst.
- After unlock, the next valid sample is treated as a SEARCH sample: a full re-acquisition of LOCK_COUNT samples is required.

Test Plan:
- Acquire: rst, then a=b=0, sums 0x00,0x02,0x04 on consecutive cycles -> locked=1 the cycle after the 3rd sample; cnt_out=0x04; err_count=0.
- Operand removal with wrap: a=0x10, b=0xF0, sum sequence giving cnt 0xFC,0xFE,0x00,0x02 -> lock achieved; cnt_out=0x02; no err_pulse across the wrap.
- Single glitch while locked: locked at cnt=0x04, next sample r=0x07 (expected 0x06), then r=0x08 -> one err_pulse, err_count=1, locked stays 1, next sample accepted with no error.
- Unlock: locked, two consecutive wrong samples -> err_count=2, locked=0 after the 2nd; then samples 0x20,0x22,0x24 -> relock after 0x24.
- Gaps and acquisition restart: in SEARCH, send 0x00, 0x02, idle 3 cycles (in_valid=0), 0x05, 0x07, 0x09 -> no lock before 0x09; locked=1 after 0x09; err_pulse never asserted.
- Saturation, clear and reset: force 300 locked mismatches with UNLOCK_ERRORS overridden to 255 -> err_count stays 255; err_clr coincident with mismatch -> err_count=0, err_pulse=1; rst mid-lock -> all outputs 0 next cycle.
